// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared constants for the unified-memory arbiter: address,
//                line and tag widths, FSM state encodings and owner codes.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

    localparam int ADDR_W = 14;             // line address, word address [15:2]
    localparam int LINE_W = 64;             // cache line width
    localparam int TAG_W  = 8;              // cache tag width
    localparam int IDX_W  = ADDR_W - TAG_W; // cache index width

    typedef logic [1:0] state_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [0:0] OWN_I = 1'b0;
    localparam logic [0:0] OWN_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin pick between the I and D miss requests.
//                On a tie the side that was not served last wins.
//  Ports       : req_i, req_d  - request levels
//                last_d        - last-served pointer (0 = I, 1 = D)
//                gnt_valid     - at least one request present
//                gnt_d         - winner is D (else I)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import mem_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_d,
    output logic gnt_valid,
    output logic gnt_d
);

    assign gnt_valid = req_i | req_d;
    // D wins when alone, or on a tie when I was served last.
    assign gnt_d     = req_d & (~req_i | (last_d == OWN_I));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares the single-ported unified memory between the I-cache
//                and D-cache miss paths. Grants one requester at a time with
//                round-robin priority, writes back a dirty D victim first,
//                then fills the line and strobes it into the owning cache.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                i_req, i_addr         - I-cache miss request / line address
//                d_req, d_addr         - D-cache miss request / line address
//                d_dirty, d_victim_tag - D victim state for write-back
//                m_rdy, m_rd_data      - memory completion / read line
//                m_addr, m_re, m_we    - memory address and commands
//                i_gnt, d_gnt          - requester owns the memory
//                i_fill_we, d_fill_we  - one-cycle fill strobes
//                fill_data             - registered fill line
//                busy                  - arbiter not idle
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_dirty,
    input  logic [TAG_W-1:0]  d_victim_tag,
    input  logic              m_rdy,
    input  logic [LINE_W-1:0] m_rd_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic [LINE_W-1:0] fill_data,
    output logic              busy
);

    state_t              r_state;
    logic                r_owner;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [TAG_W-1:0]    r_tag;
    logic [LINE_W-1:0]   r_fill_data;

    logic                w_valid;
    logic                w_pick_d;

    rr_arb2 u_rr_arb2 (
        .req_i     (i_req),
        .req_d     (d_req),
        .last_d    (r_last),
        .gnt_valid (w_valid),
        .gnt_d     (w_pick_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_I;
            r_last      <= OWN_I;
            r_addr      <= '0;
            r_tag       <= '0;
            r_fill_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_pick_d;
                        r_addr  <= w_pick_d ? d_addr : i_addr;
                        r_tag   <= d_victim_tag;
                        // Write-back decision is taken at grant time, so
                        // later changes on d_dirty do not matter.
                        r_state <= (w_pick_d && d_dirty) ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (m_rdy) begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (m_rdy) begin
                        r_fill_data <= m_rd_data;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory controls decode purely from state, so an asynchronous reset
    // drops them at once and WB/FILL can never overlap.
    always_comb begin
        m_addr = '0;
        m_re   = 1'b0;
        m_we   = 1'b0;
        case (r_state)
            S_WB: begin
                m_we   = 1'b1;
                m_addr = {r_tag, r_addr[IDX_W-1:0]};
            end
            S_FILL: begin
                m_re   = 1'b1;
                m_addr = r_addr;
            end
            default: begin
                m_addr = '0;
            end
        endcase
    end

    assign busy      = (r_state != S_IDLE);
    assign i_gnt     = busy && (r_owner == OWN_I);
    assign d_gnt     = busy && (r_owner == OWN_D);
    assign i_fill_we = (r_state == S_DONE) && (r_owner == OWN_I);
    assign d_fill_we = (r_state == S_DONE) && (r_owner == OWN_D);
    assign fill_data = r_fill_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [13:0] i_addr;
    logic        d_req;
    logic [13:0] d_addr;
    logic        d_dirty;
    logic [7:0]  d_victim_tag;
    logic        m_rdy;
    logic [63:0] m_rd_data;
    logic [13:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic        i_gnt;
    logic        d_gnt;
    logic        i_fill_we;
    logic        d_fill_we;
    logic [63:0] fill_data;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;
    int i_fill_cnt = 0;
    int d_fill_cnt = 0;
    logic overlap_seen = 1'b0;

    mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_dirty      (d_dirty),
        .d_victim_tag (d_victim_tag),
        .m_rdy        (m_rdy),
        .m_rd_data    (m_rd_data),
        .m_addr       (m_addr),
        .m_re         (m_re),
        .m_we         (m_we),
        .i_gnt        (i_gnt),
        .d_gnt        (d_gnt),
        .i_fill_we    (i_fill_we),
        .d_fill_we    (d_fill_we),
        .fill_data    (fill_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_re && m_we) overlap_seen = 1'b1;
        if (i_fill_we) i_fill_cnt++;
        if (d_fill_we) d_fill_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after the grant edge of a clean fill; returns in DONE.
    task automatic serve(input string tag, input logic own_d, input logic [13:0] addr,
                         input logic [63:0] data, input int lat);
        check_val({tag, "_gnt_i"}, i_gnt, !own_d);
        check_val({tag, "_gnt_d"}, d_gnt, own_d);
        check_val({tag, "_re"},    m_re, 1);
        check_val({tag, "_we"},    m_we, 0);
        check_val({tag, "_addr"},  m_addr, addr);
        for (int k = 1; k < lat; k++) begin
            step();
            check_val({tag, "_re_hold"},   m_re, 1);
            check_val({tag, "_addr_hold"}, m_addr, addr);
            check_val({tag, "_no_strobe"}, i_fill_we | d_fill_we, 0);
        end
        m_rdy = 1'b1;
        m_rd_data = data;
        step();
        m_rdy = 1'b0;
        m_rd_data = '0;
        check_val({tag, "_fill_i"}, i_fill_we, !own_d);
        check_val({tag, "_fill_d"}, d_fill_we, own_d);
        check_val({tag, "_data"},   fill_data, data);
        check_val({tag, "_re_off"}, m_re, 0);
        check_val({tag, "_busy_done"}, busy, 1);
    endtask

    int cnt_before;

    initial begin
        rst_n = 1'b0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_addr = '0; d_dirty = 0; d_victim_tag = '0;
        m_rdy = 0; m_rd_data = '0;
        step();
        step();
        check_val("rst_busy", busy, 0);
        check_val("rst_re_we", {m_re, m_we}, 0);
        check_val("rst_gnt", {i_gnt, d_gnt}, 0);
        check_val("rst_fill", {i_fill_we, d_fill_we}, 0);
        check_val("rst_data", fill_data, 0);
        check_val("rst_addr", m_addr, 0);
        rst_n = 1'b1;
        step();

        // I-only miss, latency 4: m_re cycles 1-4, strobe cycle 5, idle cycle 6.
        i_req = 1; i_addr = 14'h0123;
        step();
        serve("i_only", 1'b0, 14'h0123, 64'h1111_2222_3333_4444, 4);
        i_req = 0;
        step();
        check_val("i_only_idle", busy, 0);
        check_val("i_only_strobe_off", i_fill_we, 0);

        // Stray m_rdy in IDLE.
        m_rdy = 1; m_rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        m_rdy = 0; m_rd_data = '0;
        check_val("stray_busy", busy, 0);
        check_val("stray_strobe", {i_fill_we, d_fill_we}, 0);
        check_val("stray_data", fill_data, 64'h1111_2222_3333_4444);
        step();
        check_val("stray_busy2", busy, 0);
        check_val("stray_strobe2", {i_fill_we, d_fill_we}, 0);

        // D dirty miss: write-back to {7F,05} then fill from 2A05.
        d_req = 1; d_addr = 14'h2A05; d_dirty = 1; d_victim_tag = 8'h7F;
        step();
        check_val("dirty_we", m_we, 1);
        check_val("dirty_re", m_re, 0);
        check_val("dirty_wb_addr", m_addr, 14'h1FC5);
        check_val("dirty_gnt", {i_gnt, d_gnt}, 2'b01);
        step();
        check_val("dirty_we_hold", m_we, 1);
        check_val("dirty_wb_addr_hold", m_addr, 14'h1FC5);
        m_rdy = 1;
        step();
        m_rdy = 0;
        serve("dirty", 1'b1, 14'h2A05, 64'hAAAA_5555_0F0F_F0F0, 2);
        d_req = 0; d_dirty = 0;
        step();
        check_val("dirty_idle", busy, 0);

        // Reset during FILL cycle 2 with I held; re-granted after release.
        i_req = 1; i_addr = 14'h0155;
        step();
        check_val("rst_mid_re1", m_re, 1);
        step();
        cnt_before = i_fill_cnt;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mid_re", m_re, 0);
        check_val("rst_mid_gnt", i_gnt, 0);
        check_val("rst_mid_busy", busy, 0);
        step();
        check_val("rst_mid_hold", {busy, i_fill_we}, 0);
        rst_n = 1'b1;
        check_val("rst_mid_nostrobe", i_fill_cnt, cnt_before);
        step();
        serve("regrant", 1'b0, 14'h0155, 64'h0123_4567_89AB_CDEF, 3);
        i_req = 0;
        step();
        check_val("regrant_cnt", i_fill_cnt, cnt_before + 1);

        // Tie: pointer is I, so D first, then I.
        cnt_before = i_fill_cnt + d_fill_cnt;
        i_req = 1; i_addr = 14'h0AAA;
        d_req = 1; d_addr = 14'h0BBB; d_dirty = 0;
        step();
        serve("tie_d", 1'b1, 14'h0BBB, 64'h0000_0000_0000_00D1, 2);
        d_req = 0;
        step();
        check_val("tie_idle", busy, 0);
        step();
        serve("tie_i", 1'b0, 14'h0AAA, 64'h0000_0000_0000_00A1, 2);
        i_req = 0;
        step();
        check_val("tie_strobes", i_fill_cnt + d_fill_cnt, cnt_before + 2);

        // D clean miss; I arrives mid-access and waits through DONE and IDLE.
        d_req = 1; d_addr = 14'h0333; d_dirty = 0;
        step();
        i_req = 1; i_addr = 14'h0044;
        serve("d_wait", 1'b1, 14'h0333, 64'hCAFE_F00D_1234_5678, 3);
        d_req = 0;
        check_val("i_wait_done", i_gnt, 0);
        step();
        check_val("i_wait_idle_busy", busy, 0);
        check_val("i_wait_idle_gnt", i_gnt, 0);
        step();
        serve("i_after", 1'b0, 14'h0044, 64'h8765_4321_0FED_CBA9, 2);
        i_req = 0;
        step();
        check_val("final_idle", busy, 0);

        check_val("no_overlap", overlap_seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
